// File: rtl/acc_scheduler_pkg.sv
// Shared definitions for the accumulator shift-buffer scheduler: sizing,
// partial-sum width derivation and the controller state encoding.
package acc_scheduler_pkg;

  localparam int ACC_SIZE           = 8;
  localparam int ACC_TILE_CNT_WIDTH = 8;

  // Product width plus headroom for summing SIZE products, plus one guard bit.
  function automatic int psum_width(input int size);
    return 8 * 4 + 4 + size + 1;
  endfunction

  localparam int ACC_PSUM_WIDTH = psum_width(ACC_SIZE);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FILL  = 3'd1;
  localparam logic [2:0] ACCUM = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_FILL  = FILL,
    S_ACCUM = ACCUM,
    S_DRAIN = DRAIN,
    S_DONE  = DONE
  } state_e;

endpackage

// File: rtl/acc_scheduler.sv
// Sequencing controller for the accumulator shift buffer. Tile 0 writes raw
// partial sums, later tiles add onto the buffer tail, then the finished sums
// are drained over valid/ready while zeros are shifted in behind them.
// The buffer storage itself lives outside this block.
module acc_scheduler
  import acc_scheduler_pkg::*;
#(
  parameter int SIZE              = ACC_SIZE,
  parameter int TILE_CNT_WIDTH    = ACC_TILE_CNT_WIDTH,
  parameter int PARTIAL_SUM_WIDTH = psum_width(SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [TILE_CNT_WIDTH-1:0]    num_tiles,
  output logic                         busy,
  output logic                         done,
  input  logic                         psum_valid,
  output logic                         psum_ready,
  input  logic [PARTIAL_SUM_WIDTH-1:0] psum_in,
  output logic                         acc_write_enable,
  output logic [PARTIAL_SUM_WIDTH-1:0] acc_data,
  input  logic [PARTIAL_SUM_WIDTH-1:0] acc_tail_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PARTIAL_SUM_WIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ROW_W-1:0]          LAST_ROW = ROW_W'(SIZE - 1);
  localparam logic [TILE_CNT_WIDTH-1:0] ONE_TILE = TILE_CNT_WIDTH'(1);

  state_e                    state_q, state_d;
  logic [ROW_W-1:0]          row_cnt_q, row_cnt_d;
  logic [TILE_CNT_WIDTH-1:0] tile_cnt_q, tile_cnt_d;
  logic [TILE_CNT_WIDTH-1:0] num_tiles_q, num_tiles_d;
  logic                      last_row;

  assign last_row = (row_cnt_q == LAST_ROW);

  // Next-state, counter updates and every buffer/handshake output.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    state_d          = state_q;
    row_cnt_d        = row_cnt_q;
    tile_cnt_d       = tile_cnt_q;
    num_tiles_d      = num_tiles_q;
    busy             = 1'b0;
    done             = 1'b0;
    psum_ready       = 1'b0;
    acc_write_enable = 1'b0;
    acc_data         = '0;
    out_valid        = 1'b0;
    out_data         = '0;
    out_last         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_tiles_d = num_tiles;
          row_cnt_d   = '0;
          tile_cnt_d  = '0;
          state_d     = S_FILL;
        end
      end

      S_FILL: begin
        busy       = 1'b1;
        psum_ready = 1'b1;
        acc_data   = psum_in;
        if (psum_valid) begin
          acc_write_enable = 1'b1;
          row_cnt_d        = row_cnt_q + 1'b1;
          if (last_row) begin
            row_cnt_d = '0;
            // A latched count of 0 or 1 is a single-tile job.
            if (num_tiles_q <= ONE_TILE) begin
              state_d = S_DRAIN;
            end else begin
              tile_cnt_d = ONE_TILE;
              state_d    = S_ACCUM;
            end
          end
        end
      end

      S_ACCUM: begin
        busy       = 1'b1;
        psum_ready = 1'b1;
        // Single W-bit adder; the carry-out is dropped so the sum wraps.
        acc_data   = psum_in + acc_tail_in;
        if (psum_valid) begin
          acc_write_enable = 1'b1;
          row_cnt_d        = row_cnt_q + 1'b1;
          if (last_row) begin
            row_cnt_d  = '0;
            tile_cnt_d = tile_cnt_q + 1'b1;
            if (tile_cnt_q == num_tiles_q - ONE_TILE) begin
              state_d = S_DRAIN;
            end
          end
        end
      end

      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = acc_tail_in;
        out_last  = last_row;
        if (out_ready) begin
          // Shifting a zero in advances the next finished row to the tail.
          acc_write_enable = 1'b1;
          acc_data         = '0;
          row_cnt_d        = row_cnt_q + 1'b1;
          if (last_row) begin
            row_cnt_d = '0;
            state_d   = S_DONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state and counters; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: only control state is reset here. The buffer storage is left
    // unreset on purpose because FILL overwrites every entry before use.
    if (!rst) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      tile_cnt_q  <= '0;
      num_tiles_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the
      // values present before the edge, independent of statement order.
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      tile_cnt_q  <= tile_cnt_d;
      num_tiles_q <= num_tiles_d;
    end
  end

endmodule
